// File: rtl/o2_clk_reset_gen.sv
// Reset sequencer and clock-enable generator behind the system PLL.
// It qualifies PLL lock, holds the core in reset, and divides clk_sys into the CPU/VDC strobes.
module o2_clk_reset_gen #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RESET_HOLD_CYCLES  = 256,
  parameter int CPU_DIV_NTSC       = 4,
  parameter int VDC_DIV_NTSC       = 3,
  parameter int CPU_DIV_PAL        = 5,
  parameter int VDC_DIV_PAL        = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic pll_locked,
  input  logic pal,
  input  logic ext_reset,
  output logic core_reset,
  output logic ready,
  output logic ce_cpu,
  output logic ce_vdc,
  output logic ce_vdc_n
);

  localparam logic [1:0] S_WAIT_LOCK = 2'd0;
  localparam logic [1:0] S_STABLE    = 2'd1;
  localparam logic [1:0] S_HOLD      = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES
                                                                    : RESET_HOLD_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int DIV_A   = (CPU_DIV_NTSC > CPU_DIV_PAL) ? CPU_DIV_NTSC : CPU_DIV_PAL;
  localparam int DIV_B   = (VDC_DIV_NTSC > VDC_DIV_PAL) ? VDC_DIV_NTSC : VDC_DIV_PAL;
  localparam int DIV_MAX = (DIV_A > DIV_B) ? DIV_A : DIV_B;
  localparam int DW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [CW-1:0] LS_TERM = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] RH_TERM = CW'(RESET_HOLD_CYCLES - 1);

  localparam logic [DW-1:0] CPU_TERM_N = DW'(CPU_DIV_NTSC - 1);
  localparam logic [DW-1:0] CPU_TERM_P = DW'(CPU_DIV_PAL - 1);
  localparam logic [DW-1:0] VDC_TERM_N = DW'(VDC_DIV_NTSC - 1);
  localparam logic [DW-1:0] VDC_TERM_P = DW'(VDC_DIV_PAL - 1);
  localparam logic [DW-1:0] VDC_HALF_N = DW'((VDC_DIV_NTSC / 2 > 0) ? VDC_DIV_NTSC / 2 - 1 : 0);
  localparam logic [DW-1:0] VDC_HALF_P = DW'((VDC_DIV_PAL / 2 > 0) ? VDC_DIV_PAL / 2 - 1 : 0);

  logic          lock_m, lock_s;
  logic [1:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          pal_lat, pal_lat_nxt;
  logic          div_clr, running;
  logic [DW-1:0] cpu_cnt, cpu_nxt, vdc_cnt, vdc_nxt;
  logic [DW-1:0] cpu_term, vdc_term, vdc_half;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_locked;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pal_lat_nxt = pal_lat;
    div_clr     = 1'b0;
    case (state)
      S_WAIT_LOCK: begin
        cnt_nxt = '0;
        if (lock_s) state_nxt = S_STABLE;
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == LS_TERM) begin
          state_nxt   = S_HOLD;
          cnt_nxt     = '0;
          pal_lat_nxt = pal;
          div_clr     = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (pal != pal_lat) begin
          // Standard changed mid-hold: restart the hold with the new dividers.
          cnt_nxt     = '0;
          pal_lat_nxt = pal;
          div_clr     = 1'b1;
        end else if (ext_reset) begin
          cnt_nxt = '0;
        end else if (cnt == RH_TERM) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        if (!lock_s) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (ext_reset || (pal != pal_lat)) begin
          state_nxt   = S_HOLD;
          cnt_nxt     = '0;
          pal_lat_nxt = pal;
          div_clr     = 1'b1;
        end
      end
    endcase
  end

  // Strobes decode from the next divider counts so every output stays a plain flop.
  always_comb begin
    running  = (state_nxt == S_HOLD) || (state_nxt == S_RUN);
    cpu_term = pal_lat_nxt ? CPU_TERM_P : CPU_TERM_N;
    vdc_term = pal_lat_nxt ? VDC_TERM_P : VDC_TERM_N;
    vdc_half = pal_lat_nxt ? VDC_HALF_P : VDC_HALF_N;
    cpu_nxt  = '0;
    vdc_nxt  = '0;
    if (running && !div_clr) begin
      cpu_nxt = (cpu_cnt == cpu_term) ? '0 : cpu_cnt + 1'b1;
      vdc_nxt = (vdc_cnt == vdc_term) ? '0 : vdc_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= S_WAIT_LOCK;
      cnt        <= '0;
      pal_lat    <= 1'b0;
      cpu_cnt    <= '0;
      vdc_cnt    <= '0;
      core_reset <= 1'b1;
      ready      <= 1'b0;
      ce_cpu     <= 1'b0;
      ce_vdc     <= 1'b0;
      ce_vdc_n   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pal_lat    <= pal_lat_nxt;
      cpu_cnt    <= cpu_nxt;
      vdc_cnt    <= vdc_nxt;
      core_reset <= (state_nxt != S_RUN);
      ready      <= (state_nxt == S_RUN);
      ce_cpu     <= running && (cpu_nxt == cpu_term);
      ce_vdc     <= running && (vdc_nxt == vdc_term);
      ce_vdc_n   <= running && (vdc_nxt == vdc_half);
    end
  end

endmodule
